request_rr_arbiter: RTL

- Round-robin scheduler that shares one downstream request channel between N_STREAMS requesters.
- Tags each forwarded request with its source stream index. The completion path returns that index as the dest field, which the completion demultiplexer uses for routing.
- Limits outstanding (issued, not yet completed) requests per stream with credit counters. Completions for each stream are counted back in on a dedicated input.

---
 rtl/request_rr_arbiter_if.sv | 25 ++
 rtl/request_rr_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/request_rr_arbiter_if.sv
// Request-side and forwarded-side bundle of the round-robin request arbiter.
// Valid/ready: a beat transfers on a rising clk edge where valid && ready; once valid is high, data and index hold until that edge.
interface request_rr_arbiter_if #(
  parameter int  N_STREAMS = 2,
  parameter type DATA_TYPE = logic [63:0],
  parameter int  N_BITS    = $clog2(N_STREAMS)
);
  DATA_TYPE             i_data [N_STREAMS];
  logic [N_STREAMS-1:0] i_valid;
  logic [N_STREAMS-1:0] i_ready;
  DATA_TYPE             o_data;
  logic [N_BITS-1:0]    o_stream;
  logic                 o_valid;
  logic                 o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_stream, o_valid
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_stream, o_valid
  );
endinterface

// File: rtl/request_rr_arbiter.sv
// Round-robin arbiter sharing one registered request channel between N_STREAMS
// requesters, with per-stream outstanding-request credit counters.
module request_rr_arbiter #(
  parameter int  N_STREAMS       = 2,
  parameter type DATA_TYPE       = logic [63:0],
  parameter int  MAX_OUTSTANDING = 8,
  parameter int  N_BITS          = $clog2(N_STREAMS),
  parameter int  CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  request_rr_arbiter_if.slave     bus,
  input  logic                    cpl_valid,
  input  logic [N_BITS-1:0]       cpl_stream,
  output logic [CNT_BITS-1:0]     outstanding [N_STREAMS],
  output logic                    cpl_err
);

  logic [N_BITS-1:0]    r_ptr;
  logic [CNT_BITS-1:0]  r_cnt [N_STREAMS];
  logic                 r_err;
  logic                 r_valid;
  DATA_TYPE             r_data;
  logic [N_BITS-1:0]    r_stream;

  logic [N_STREAMS-1:0] w_elig;
  logic [N_STREAMS-1:0] w_inc;
  logic [N_STREAMS-1:0] w_dec;
  logic [N_BITS:0]      w_idx;
  logic [N_BITS-1:0]    w_grant;
  logic                 w_grant_vld;
  logic                 w_load;
  logic                 w_cpl_ok;

  assign w_load = !r_valid || bus.o_ready;

  // Credit check uses the registered count, so a completion frees credit only next cycle.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < N_STREAMS; k++) begin
      w_elig[k] = bus.i_valid[k] && (r_cnt[k] < CNT_BITS'(MAX_OUTSTANDING));
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    for (int off = 0; off < N_STREAMS; off++) begin
      w_idx = {1'b0, r_ptr} + (N_BITS+1)'(off);
      if (w_idx >= (N_BITS+1)'(N_STREAMS)) begin
        w_idx = w_idx - (N_BITS+1)'(N_STREAMS);
      end
      if (!w_grant_vld && w_elig[w_idx[N_BITS-1:0]]) begin
        w_grant     = w_idx[N_BITS-1:0];
        w_grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    bus.i_ready = '0;
    for (int k = 0; k < N_STREAMS; k++) begin
      bus.i_ready[k] = w_load && w_grant_vld && (w_grant == N_BITS'(k));
    end
  end

  // A completion on a zero-count stream is legal only when it pairs with a same-cycle issue.
  always_comb begin
    w_inc    = '0;
    w_dec    = '0;
    w_cpl_ok = 1'b0;
    for (int k = 0; k < N_STREAMS; k++) begin
      w_inc[k] = bus.i_valid[k] && bus.i_ready[k];
      if (cpl_valid && (cpl_stream == N_BITS'(k)) && ((r_cnt[k] != '0) || w_inc[k])) begin
        w_dec[k] = 1'b1;
        w_cpl_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STREAMS; k++) begin
        r_cnt[k] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < N_STREAMS; k++) begin
        if (w_inc[k] && !w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] + CNT_BITS'(1);
        end else if (!w_inc[k] && w_dec[k]) begin
          r_cnt[k] <= r_cnt[k] - CNT_BITS'(1);
        end
      end
      if (cpl_valid && !w_cpl_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_stream <= '0;
      r_ptr    <= '0;
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_data   <= bus.i_data[w_grant];
        r_stream <= w_grant;
        r_valid  <= 1'b1;
        r_ptr    <= (w_grant == N_BITS'(N_STREAMS - 1)) ? '0 : w_grant + N_BITS'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_data   = r_data;
  assign bus.o_stream = r_stream;
  assign bus.o_valid  = r_valid;
  assign outstanding  = r_cnt;
  assign cpl_err      = r_err;

endmodule
